dmem_arbiter: RTL and testbench

Two-master arbiter for the single data memory port. Master 0 is the core load/store unit and master 1 is a secondary master (debug or DMA). Both use the core's valid/ready data memory protocol. The block arbitrates round-robin, registers the winning request and owns the memory until it completes. A watchdog aborts transactions the memory never acknowledges.

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory port between two masters.
// Registers the winning request, owns the port until completion or watchdog abort.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_valid_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m0_we_i,
    output logic                    m0_ready_o,
    output logic                    m0_err_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_valid_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m1_we_i,
    output logic                    m1_ready_o,
    output logic                    m1_err_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    mem_valid_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    input  logic                    mem_ready_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0]         we_q, we_d;
    logic                  winner;
    logic                  done;
    logic                  abort;
    logic                  wd_hit;

    assign wd_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        winner  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    // On a tie, the master that did not win last time goes.
                    winner  = (m0_valid_i && m1_valid_i) ? ~last_q : m1_valid_i;
                    addr_d  = winner ? m1_addr_i  : m0_addr_i;
                    wdata_d = winner ? m1_wdata_i : m0_wdata_i;
                    we_d    = winner ? m1_we_i    : m0_we_i;
                    owner_d = winner;
                    last_d  = winner;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (wd_hit) begin
                    done    = 1'b1;
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign mem_valid_o = (state_q == BUSY);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = we_q;

    assign m0_ready_o = done && !owner_q;
    assign m1_ready_o = done && owner_q;
    assign m0_err_o   = abort && !owner_q;
    assign m1_err_o   = abort && owner_q;
    assign m0_rdata_o = mem_rdata_i;
    assign m1_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 4-cycle watchdog.
// Inputs change 1 time unit after posedge, outputs are sampled 1 unit later.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_we, m1_we;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_ready, mem_ready_r, zw;
    logic [31:0] mem_rdata;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_vld;

    always #5 clk = ~clk;

    // Zero-wait memory answers in the first BUSY cycle.
    assign mem_ready = zw ? mem_valid : mem_ready_r;

    dmem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_valid_i (m0_valid),
        .m0_addr_i  (m0_addr),
        .m0_wdata_i (m0_wdata),
        .m0_we_i    (m0_we),
        .m0_ready_o (m0_ready),
        .m0_err_o   (m0_err),
        .m0_rdata_o (m0_rdata),
        .m1_valid_i (m1_valid),
        .m1_addr_i  (m1_addr),
        .m1_wdata_i (m1_wdata),
        .m1_we_i    (m1_we),
        .m1_ready_o (m1_ready),
        .m1_err_o   (m1_err),
        .m1_rdata_o (m1_rdata),
        .mem_valid_o(mem_valid),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o   (mem_we),
        .mem_ready_i(mem_ready),
        .mem_rdata_i(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, " mem_valid"}, 64'(mem_valid), 64'd0);
        check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, " mem_we"}, 64'(mem_we), 64'd0);
        check({tag, " rdy_err"},
              64'({m1_ready, m1_err, m0_ready, m0_err}), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        check_reset_outs("reset");
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        m0_valid = 0; m1_valid = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_we = 0; m1_we = 0;
        mem_ready_r = 0; zw = 0; mem_rdata = 0;

        // Reset and single read with 3 BUSY cycles
        do_reset();
        m0_valid = 1; m0_addr = 32'h100; m0_we = 4'h0;
        #1;
        check("t1 idle mem_valid", 64'(mem_valid), 64'd0);
        n_vld = 0;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            if (k == 3) begin
                mem_ready_r = 1;
                mem_rdata = 32'hDEADBEEF;
            end
            #1;
            n_vld += int'(mem_valid);
            if (k < 3) begin
                check("t1 early ready", 64'({m1_ready, m0_ready}), 64'd0);
            end else begin
                check("t1 ready", 64'({m1_ready, m0_ready}), 64'b01);
                check("t1 err", 64'(m0_err), 64'd0);
                check("t1 rdata", 64'(m0_rdata), 64'hDEADBEEF);
                check("t1 addr", 64'(mem_addr), 64'h100);
            end
        end
        cyc();
        m0_valid = 0; mem_ready_r = 0;
        #1;
        n_vld += int'(mem_valid);
        check("t1 valid cycles", 64'(n_vld), 64'd3);

        // Simultaneous requests after reset, zero-wait memory
        do_reset();
        zw = 1;
        m0_valid = 1; m0_addr = 32'h10; m0_wdata = 32'h11223344; m0_we = 4'hF;
        m1_valid = 1; m1_addr = 32'h20; m1_we = 4'h0;
        cyc();
        check("t2 first addr", 64'(mem_addr), 64'h10);
        check("t2 first wdata", 64'(mem_wdata), 64'h11223344);
        check("t2 first we", 64'(mem_we), 64'hF);
        check("t2 first ready", 64'({m1_ready, m0_ready}), 64'b01);
        cyc();
        m0_valid = 0;
        #1;
        check("t2 gap valid", 64'(mem_valid), 64'd0);
        cyc();
        check("t2 second addr", 64'(mem_addr), 64'h20);
        check("t2 second ready", 64'({m1_ready, m0_ready}), 64'b10);
        check("t2 second err", 64'({m1_err, m0_err}), 64'd0);
        cyc();
        m1_valid = 0;

        // Continuous contention for 8 transactions
        m0_valid = 1; m0_addr = 32'hA0; m0_we = 4'h1;
        m1_valid = 1; m1_addr = 32'hB0; m1_we = 4'h0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check($sformatf("t3 grant %0d", i),
                  64'({m1_ready, m0_ready}), (i % 2 == 0) ? 64'b01 : 64'b10);
            check($sformatf("t3 addr %0d", i), 64'(mem_addr),
                  (i % 2 == 0) ? 64'hA0 : 64'hB0);
            cyc();
            check($sformatf("t3 idle %0d", i),
                  64'({mem_valid, m1_ready, m0_ready}), 64'd0);
        end
        m0_valid = 0; m1_valid = 0;
        zw = 0;
        cyc();

        // Watchdog abort on m1, then a stray late response
        m1_valid = 1; m1_addr = 32'h40;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k < 4) begin
                check($sformatf("t4 busy %0d", k),
                      64'({mem_valid, m1_ready, m0_ready}), 64'b100);
            end else begin
                check("t4 abort rdy", 64'({m1_ready, m0_ready}), 64'b10);
                check("t4 abort err", 64'({m1_err, m0_err}), 64'b10);
            end
        end
        cyc();
        m1_valid = 0;
        #1;
        check("t4 valid drop", 64'(mem_valid), 64'd0);
        mem_ready_r = 1;
        #1;
        check("t4 late resp", 64'({m1_ready, m0_ready, m1_err, m0_err}), 64'd0);
        cyc();
        mem_ready_r = 0;
        #1;
        check("t4 still idle", 64'(mem_valid), 64'd0);

        // Ready coincides with the watchdog limit
        m0_valid = 1; m0_addr = 32'h50; m0_we = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 4) begin
                mem_ready_r = 1;
                mem_rdata = 32'hCAFEF00D;
            end
            #1;
        end
        check("t5 ready", 64'({m1_ready, m0_ready}), 64'b01);
        check("t5 err", 64'({m1_err, m0_err}), 64'd0);
        check("t5 rdata", 64'(m0_rdata), 64'hCAFEF00D);
        cyc();
        m0_valid = 0; mem_ready_r = 0;
        #1;
        check("t5 valid drop", 64'(mem_valid), 64'd0);

        // Reset in the middle of an m0 write
        m0_valid = 1; m0_addr = 32'h60; m0_wdata = 32'hA5A5A5A5; m0_we = 4'b0011;
        cyc();
        check("t6 busy addr", 64'(mem_addr), 64'h60);
        check("t6 busy valid", 64'(mem_valid), 64'd1);
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outs("t6 async");
        mem_ready_r = 1;
        #1;
        check("t6 no ready", 64'({m1_ready, m0_ready}), 64'd0);
        cyc();
        check("t6 no ready clk", 64'({m1_ready, m0_ready}), 64'd0);
        mem_ready_r = 0;
        m0_valid = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("t6 idle after", 64'(mem_valid), 64'd0);
        m1_valid = 1; m1_addr = 32'h70; m1_we = 4'h0;
        cyc();
        check("t6 next addr", 64'(mem_addr), 64'h70);
        mem_ready_r = 1; mem_rdata = 32'h0BADF00D;
        #1;
        check("t6 next ready", 64'({m1_ready, m0_ready}), 64'b10);
        check("t6 next rdata", 64'(m1_rdata), 64'h0BADF00D);
        cyc();
        m1_valid = 0; mem_ready_r = 0;
        #1;
        check("t6 final idle", 64'(mem_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
